// File: rtl/alu_seq_pkg.sv
// Shared state, opcode and operand-transform helpers for the chunked alu_seq datapath.
// ALU_SEQ_CARRYIN_EN (defined in the top) selects external carry-in for arithmetic 110/111.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        B_OP2  = 2'd0,
        B_INV  = 2'd1,
        B_ZERO = 2'd2,
        B_ONES = 2'd3
    } bsel_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_NEG  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_SBB  = 3'b111;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOT   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_XNOR  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Without an external carry-in, 110/111 fall back to plain ADD/SUB.
    function automatic logic init_cin(input logic mode, input logic [2:0] opsel,
                                      input logic ext_en, input logic ext_cin);
        logic c;
        c = 1'b0;
        if (mode) begin
            case (opsel)
                OP_SUB, OP_INC, OP_NEG: c = 1'b1;
                OP_ADC:                 c = ext_en ? ext_cin : 1'b0;
                OP_SBB:                 c = ext_en ? ext_cin : 1'b1;
                default:                c = 1'b0;
            endcase
        end
        return c;
    endfunction

    function automatic bsel_t b_xform(input logic mode, input logic [2:0] opsel);
        bsel_t b;
        b = B_OP2;
        if (mode) begin
            case (opsel)
                OP_ADD, OP_ADC:         b = B_OP2;
                OP_SUB, OP_SBB, OP_NEG: b = B_INV;
                OP_INC, OP_PASS:        b = B_ZERO;
                OP_DEC:                 b = B_ONES;
                default:                b = B_OP2;
            endcase
        end
        return b;
    endfunction

    function automatic logic a_zero(input logic mode, input logic [2:0] opsel);
        return mode && (opsel == OP_NEG);
    endfunction

endpackage

// File: rtl/alu_seq_chunk.sv
// One CHUNK-bit slice of the ALU: adder for arithmetic mode, bitwise ops for logic mode.
module alu_chunk
    import alu_seq_pkg::*;
#(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             mode,
    input  logic [2:0]       opsel,
    input  logic             cin,
    output logic [CHUNK-1:0] res,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // Carries are forced low in logic mode so the flags fall out as c=0, o=0.
    always_comb begin
        res   = '0;
        cout  = 1'b0;
        c_msb = 1'b0;
        if (mode) begin
            res   = w_sum[CHUNK-1:0];
            cout  = w_sum[CHUNK];
            c_msb = w_sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
        end else begin
            case (opsel)
                OP_AND:   res = a & b;
                OP_OR:    res = a | b;
                OP_XOR:   res = a ^ b;
                OP_NOT:   res = ~a;
                OP_NAND:  res = ~(a & b);
                OP_NOR:   res = ~(a | b);
                OP_XNOR:  res = ~(a ^ b);
                default:  res = b;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU processing CHUNK bits per clock, LS chunk first, with valid/ready ports.
// Optional: define ALU_SEQ_CARRYIN_EN to add the cin port and ADC/SBB on arithmetic 110/111.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       opsel,
    input  logic             mode,
`ifdef ALU_SEQ_CARRYIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [2:0]       r_opsel;
    logic             r_mode;
    logic             r_carry;
    logic             r_zacc;
    logic             r_c;
    logic             r_z;
    logic             r_o;
    logic             r_s;

    logic             w_accept;
    logic             w_last;
    logic             w_ext_en;
    logic             w_ext_cin;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    int unsigned      w_base;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_cres;
    logic             w_cout;
    logic             w_cmsb;

`ifdef ALU_SEQ_CARRYIN_EN
    assign w_ext_en  = 1'b1;
    assign w_ext_cin = cin;
`else
    assign w_ext_en  = 1'b0;
    assign w_ext_cin = 1'b0;
`endif

    // Operands are pre-transformed at acceptance so every chunk is a plain A + B + carry.
    always_comb begin
        w_a_in = a_zero(mode, opsel) ? '0 : op1;
        case (b_xform(mode, opsel))
            B_INV:   w_b_in = ~op2;
            B_ZERO:  w_b_in = '0;
            B_ONES:  w_b_in = '1;
            default: w_b_in = op2;
        endcase
    end

    assign w_base = int'(r_k) * CHUNK;
    assign w_ca   = r_a[w_base +: CHUNK];
    assign w_cb   = r_b[w_base +: CHUNK];

    alu_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (w_ca),
        .b     (w_cb),
        .mode  (r_mode),
        .opsel (r_opsel),
        .cin   (r_carry),
        .res   (w_cres),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_last = (r_k == K_LAST);
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_opsel <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_o     <= 1'b0;
            r_s     <= 1'b0;
        end else if (w_accept) begin
            r_k     <= '0;
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_opsel <= opsel;
            r_mode  <= mode;
            r_carry <= init_cin(mode, opsel, w_ext_en, w_ext_cin);
            r_zacc  <= 1'b1;
        end else if (r_state == ST_BUSY) begin
            r_res[w_base +: CHUNK] <= w_cres;
            r_carry <= w_cout;
            r_zacc  <= r_zacc & (w_cres == '0);
            r_k     <= r_k + 1'b1;
            // Flags are committed only with the most-significant chunk.
            if (w_last) begin
                r_c <= w_cout;
                r_o <= w_cout ^ w_cmsb;
                r_z <= r_zacc & (w_cres == '0);
                r_s <= w_cres[CHUNK-1];
            end
        end
    end

    assign result = r_res;
    assign c_flag = r_c;
    assign z_flag = r_z;
    assign o_flag = r_o;
    assign s_flag = r_s;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, random ops, backpressure and reset-abort sequences.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int WIDTH = 128;
    localparam int CHUNK = 32;
    localparam int N     = WIDTH / CHUNK;
`ifdef ALU_SEQ_CARRYIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
        logic             m;
        logic             ci;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        logic             o;
        logic             s;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       opsel;
    logic             mode;
`ifdef ALU_SEQ_CARRYIN_EN
    logic             cin;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_flag;
    logic             z_flag;
    logic             o_flag;
    logic             s_flag;

    vec_t sb[$];
    vec_t tbl[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    alu_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .mode      (mode),
`ifdef ALU_SEQ_CARRYIN_EN
        .cin       (cin),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .o_flag    (o_flag),
        .s_flag    (s_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [2:0] sel, input logic m, input logic ci,
                                input logic [WIDTH-1:0] res, input logic c, input logic z,
                                input logic o, input logic s);
        vec_t v;
        v.a = a; v.b = b; v.sel = sel; v.m = m; v.ci = ci;
        v.res = res; v.c = c; v.z = z; v.o = o; v.s = s;
        return v;
    endfunction

    // Reference: whole-width add with an explicit carry into the MSB.
    function automatic vec_t model(input vec_t v);
        vec_t             r;
        logic [WIDTH-1:0] aa;
        logic [WIDTH-1:0] bb;
        logic             ci;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] low;
        r  = v;
        aa = v.a;
        bb = v.b;
        ci = 1'b0;
        if (v.m) begin
            case (v.sel)
                3'b000: ci = 1'b0;
                3'b001: begin bb = ~v.b; ci = 1'b1; end
                3'b010: begin bb = '0; ci = 1'b1; end
                3'b011: bb = '1;
                3'b100: begin aa = '0; bb = ~v.b; ci = 1'b1; end
                3'b101: bb = '0;
                3'b110: ci = CIN_EN ? v.ci : 1'b0;
                default: begin bb = ~v.b; ci = CIN_EN ? v.ci : 1'b1; end
            endcase
            sum   = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
            low   = {1'b0, aa[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, ci};
            r.res = sum[WIDTH-1:0];
            r.c   = sum[WIDTH];
            r.o   = low[WIDTH-1] ^ sum[WIDTH];
        end else begin
            case (v.sel)
                3'b000:  r.res = v.a & v.b;
                3'b001:  r.res = v.a | v.b;
                3'b010:  r.res = v.a ^ v.b;
                3'b011:  r.res = ~v.a;
                3'b100:  r.res = ~(v.a & v.b);
                3'b101:  r.res = ~(v.a | v.b);
                3'b110:  r.res = ~(v.a ^ v.b);
                default: r.res = v.b;
            endcase
            r.c = 1'b0;
            r.o = 1'b0;
        end
        r.z = (r.res == '0);
        r.s = r.res[WIDTH-1];
        return r;
    endfunction

    // Output monitor: latency on each rising out_valid, scoreboard compare on each handshake.
    always @(negedge clk) begin
        vec_t e;
        if (!rst) begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (out_valid && !prev_ov) chki("latency", cyc - acc_cyc - 1, N);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chki("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk1("c_flag", c_flag, e.c);
                    chk1("z_flag", z_flag, e.z);
                    chk1("o_flag", o_flag, e.o);
                    chk1("s_flag", s_flag, e.s);
                end
            end
        end
        prev_ov = out_valid;
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input vec_t v);
        int w;
        op1 = v.a; op2 = v.b; opsel = v.sel; mode = v.m;
`ifdef ALU_SEQ_CARRYIN_EN
        cin = v.ci;
`endif
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            chki("accept_timeout", w, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            sb.push_back(v);
            op1 = {$urandom, $urandom, $urandom, $urandom};
            op2 = {$urandom, $urandom, $urandom, $urandom};
            opsel = 3'($urandom);
            mode  = 1'($urandom);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || !in_ready) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 200) chki("drain_timeout", w, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] msb;
        logic [WIDTH-1:0] a5;
        logic [WIDTH-1:0] x5a;
        vec_t             v;
        int               w;
        ones = '1;
        msb  = {1'b1, {(WIDTH-1){1'b0}}};
        a5   = {16{8'hA5}};
        x5a  = {16{8'h5A}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; opsel = '0; mode = 1'b0;
`ifdef ALU_SEQ_CARRYIN_EN
        cin = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, '0);
        chk1("rst_c", c_flag, 1'b0);
        chk1("rst_z", z_flag, 1'b0);
        chk1("rst_o", o_flag, 1'b0);
        chk1("rst_s", s_flag, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        //              a         b         sel     m     ci    res       c     z     o     s
        tbl.push_back(mk(ones,    1,        3'b000, 1'b1, 1'b0, '0,       1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(msb,     1,        3'b001, 1'b1, 1'b0, ~msb,     1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(a5,      a5,       3'b010, 1'b0, 1'b0, '0,       1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(a5,      a5,       3'b000, 1'b0, 1'b0, a5,       1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(5,       7,        3'b000, 1'b1, 1'b0, 12,       1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(~msb,    1,        3'b000, 1'b1, 1'b0, msb,      1'b0, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(ones,    0,        3'b010, 1'b1, 1'b0, '0,       1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(0,       0,        3'b011, 1'b1, 1'b0, ones,     1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(0,       1,        3'b100, 1'b1, 1'b0, ones,     1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(0,       0,        3'b100, 1'b1, 1'b0, '0,       1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(msb,     ones,     3'b101, 1'b1, 1'b0, msb,      1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(0,       0,        3'b001, 1'b0, 1'b0, '0,       1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(0,       ones,     3'b011, 1'b0, 1'b0, ones,     1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(ones,    ones,     3'b100, 1'b0, 1'b0, '0,       1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(0,       0,        3'b101, 1'b0, 1'b0, ones,     1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(a5,      x5a,      3'b110, 1'b0, 1'b0, '0,       1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(ones,    1,        3'b111, 1'b0, 1'b0, 1,        1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3,       4,        3'b110, 1'b1, 1'b0, 7,        1'b0, 1'b0, 1'b0, 1'b0));
`ifdef ALU_SEQ_CARRYIN_EN
        tbl.push_back(mk(0,       0,        3'b110, 1'b1, 1'b1, 1,        1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(5,       3,        3'b111, 1'b1, 1'b0, 1,        1'b1, 1'b0, 1'b0, 1'b0));
`else
        tbl.push_back(mk(9,       2,        3'b111, 1'b1, 1'b0, 7,        1'b1, 1'b0, 1'b0, 1'b0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i]);
            drain();
        end

        // Back-to-back random operations, checked against the reference model.
        for (int i = 0; i < 12; i++) begin
            v.a   = {$urandom, $urandom, $urandom, $urandom};
            v.b   = (i % 3 == 0) ? ~v.a : {$urandom, $urandom, $urandom, $urandom};
            v.sel = 3'($urandom);
            v.m   = 1'($urandom);
            v.ci  = 1'($urandom);
            send(model(v));
        end
        drain();

        // Backpressure: result and flags must hold in DONE while out_ready is low.
        out_ready = 1'b0;
        send(mk(ones, 1, 3'b000, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0));
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk1("bp_valid_rise", out_valid, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk("bp_result", result, '0);
            chk1("bp_c", c_flag, 1'b1);
            chk1("bp_z", z_flag, 1'b1);
            chk1("bp_o", o_flag, 1'b0);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("bp_in_ready_after", in_ready, 1'b1);
        chk1("bp_out_valid_after", out_valid, 1'b0);
        send(mk(a5, a5, 3'b000, 1'b0, 1'b0, a5, 1'b0, 1'b0, 1'b0, 1'b1));
        drain();

        // Reset during the second BUSY cycle drops the operation entirely.
        send(mk(ones, ones, 3'b000, 1'b1, 1'b0, ~128'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk("abort_result", result, '0);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk1("abort_no_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        send(mk(5, 7, 3'b000, 1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        chki("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
